// File: rtl/multi_cycle_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// and presents the result and flags together with a one-cycle Done pulse.
module multi_cycle_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_next;
  logic             b_inv;
  logic             cin_eff;
  logic             msb_ovf;

  // Operands shift right each RUN cycle, so the active chunk always sits in the
  // low CHUNK bits; B is stored already inverted for the subtract modes.
  always_comb begin
    b_inv     = Mode[0];
    cin_eff   = Mode[1] ? Cin : Mode[0];
    chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry);
    res_next  = (res >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    msb_ovf   = (a_q[CHUNK-1] == b_q[CHUNK-1]) && (chunk_sum[CHUNK-1] != a_q[CHUNK-1]);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
      Out   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            a_q   <= A;
            b_q   <= b_inv ? ~B : B;
            carry <= cin_eff;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          res   <= res_next;
          carry <= chunk_sum[CHUNK];
          cnt   <= cnt + CW'(1);
          // Last chunk: its MSB is the word MSB, so the flags come from here.
          if (cnt == LAST) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            Out   <= res_next;
            Cout  <= chunk_sum[CHUNK];
            Ovf   <= msb_ovf;
            Zero  <= (res_next == '0);
            state <= DONE;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Self-checking bench for multi_cycle_adder: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_multi_cycle_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             Start;
  logic [1:0]       Mode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Busy, Done, Cout, Ovf, Zero;
  logic [WIDTH-1:0] Out;
  logic             busy1, done1, cout1, ovf1, zero1;
  logic [WIDTH-1:0] out1;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] expOut;
  logic             expCout, expOvf, expZero;
  logic [WIDTH-1:0] lastOut;

  always #5 CLK = ~CLK;

  multi_cycle_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Mode(Mode), .A(A), .B(B), .Cin(Cin),
    .Busy(Busy), .Done(Done), .Out(Out), .Cout(Cout), .Ovf(Ovf), .Zero(Zero)
  );

  // Single-chunk variant sharing the same stimulus.
  multi_cycle_adder #(.WIDTH(WIDTH), .CHUNK(WIDTH)) dut1 (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Mode(Mode), .A(A), .B(B), .Cin(Cin),
    .Busy(busy1), .Done(done1), .Out(out1), .Cout(cout1), .Ovf(ovf1), .Zero(zero1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: unsigned sum for Out/Cout, signed integer sum for Ovf.
  task automatic model(input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    longint ua, ub, cc, sum, sa, sb, ssum;
    ua   = longint'(a);
    ub   = m[0] ? (2**WIDTH - 1 - longint'(b)) : longint'(b);
    cc   = (m == 2'b00) ? 0 : (m == 2'b01) ? 1 : longint'(c);
    sum  = ua + ub + cc;
    sa   = (ua >= 2**(WIDTH-1)) ? ua - 2**WIDTH : ua;
    sb   = (ub >= 2**(WIDTH-1)) ? ub - 2**WIDTH : ub;
    ssum = sa + sb + cc;
    expOut  = WIDTH'(sum % (2**WIDTH));
    expCout = (sum >= 2**WIDTH);
    expOvf  = (ssum > 2**(WIDTH-1) - 1) || (ssum < -(2**(WIDTH-1)));
    expZero = (expOut == '0);
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    @(negedge CLK);
    Mode = m; A = a; B = b; Cin = c; Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
  endtask

  // Entered #1 after edge number 'edges' counted from the accepting edge (=1).
  task automatic waitDone(input string tag, input logic [WIDTH-1:0] holdOut, input int startEdges);
    int edges;
    edges = startEdges;
    while (!Done && edges < 4 * N + 10) begin
      checkOutput({tag, "_busy"}, 32'(Busy), 32'd1);
      checkOutput({tag, "_hold"}, 32'(Out), 32'(holdOut));
      @(posedge CLK);
      #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 32'(edges), 32'(N + 1));
    checkOutput({tag, "_done"}, 32'(Done), 32'd1);
    checkOutput({tag, "_busyoff"}, 32'(Busy), 32'd0);
    checkOutput({tag, "_out"}, 32'(Out), 32'(expOut));
    checkOutput({tag, "_cout"}, 32'(Cout), 32'(expCout));
    checkOutput({tag, "_ovf"}, 32'(Ovf), 32'(expOvf));
    checkOutput({tag, "_zero"}, 32'(Zero), 32'(expZero));
  endtask

  task automatic runOp(input string tag, input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    model(m, a, b, c);
    applyStimulus(m, a, b, c);
    waitDone(tag, lastOut, 1);
    lastOut = expOut;
    @(posedge CLK);
    #1;
    checkOutput({tag, "_pulse"}, 32'(Done), 32'd0);
    checkOutput({tag, "_keep"}, 32'(Out), 32'(expOut));
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Mode = 2'b00; A = '0; B = '0; Cin = 1'b0;
    lastOut = '0;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("rst_busy", 32'(Busy), 32'd0);
    checkOutput("rst_done", 32'(Done), 32'd0);
    checkOutput("rst_out", 32'(Out), 32'd0);
    checkOutput("rst_flags", {29'd0, Cout, Ovf, Zero}, 32'd0);
    @(negedge CLK);
    Reset = 1'b1;

    runOp("basic_add", 2'b00, 16'h0005, 16'h0008, 1'b0);
    checkOutput("basic_add_ref", 32'(expOut), 32'h000D);
    runOp("wrap_add", 2'b00, 16'hFFFF, 16'h0001, 1'b0);
    runOp("ovf_add", 2'b00, 16'h7FFF, 16'h0001, 1'b0);
    runOp("sub_borrow", 2'b01, 16'h0005, 16'h0008, 1'b0);
    runOp("subc_noborrow", 2'b11, 16'h0010, 16'h0001, 1'b0);
    runOp("addc", 2'b10, 16'h00FF, 16'h0000, 1'b1);

    // Start while busy must be ignored.
    model(2'b00, 16'h0001, 16'h0002, 1'b0);
    applyStimulus(2'b00, 16'h0001, 16'h0002, 1'b0);
    applyStimulus(2'b00, 16'h0009, 16'h0009, 1'b0);
    waitDone("busy_start", lastOut, 2);
    lastOut = expOut;
    @(posedge CLK);
    #1;
    checkOutput("busy_start_single", {30'd0, Done, Busy}, 32'd0);

    // Back-to-back: Start presented during the DONE cycle.
    model(2'b01, 16'h1234, 16'h0234, 1'b0);
    applyStimulus(2'b01, 16'h1234, 16'h0234, 1'b0);
    waitDone("b2b_first", lastOut, 1);
    lastOut = expOut;
    model(2'b00, 16'h8000, 16'h8000, 1'b0);
    Mode = 2'b00; A = 16'h8000; B = 16'h8000; Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    waitDone("b2b_second", lastOut, 1);
    lastOut = expOut;

    // Single-chunk instance finishes one edge after acceptance.
    model(2'b11, 16'h4000, 16'hC000, 1'b1);
    applyStimulus(2'b11, 16'h4000, 16'hC000, 1'b1);
    checkOutput("n1_busy", 32'(busy1), 32'd1);
    @(posedge CLK);
    #1;
    checkOutput("n1_done", 32'(done1), 32'd1);
    checkOutput("n1_out", 32'(out1), 32'(expOut));
    checkOutput("n1_flags", {29'd0, cout1, ovf1, zero1}, {29'd0, expCout, expOvf, expZero});
    waitDone("n1_main", lastOut, 2);
    lastOut = expOut;

    // Reset in the middle of RUN aborts with no Done.
    applyStimulus(2'b00, 16'h0F0F, 16'h0101, 1'b0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    Start = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("midrst_state", {30'd0, Done, Busy}, 32'd0);
    checkOutput("midrst_out", 32'(Out), 32'd0);
    checkOutput("midrst_flags", {29'd0, Cout, Ovf, Zero}, 32'd0);
    @(posedge CLK);
    #1;
    checkOutput("midrst_ignore", {30'd0, Done, Busy}, 32'd0);
    lastOut = '0;
    @(negedge CLK);
    model(2'b10, 16'h1111, 16'h2222, 1'b1);
    Reset = 1'b1; Mode = 2'b10; A = 16'h1111; B = 16'h2222; Cin = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    waitDone("post_rst", lastOut, 1);
    lastOut = expOut;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 40; i++) begin
      runOp("rand", 2'($urandom_range(0, 3)), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_adder.md
MULTI_CYCLE_ADDER -- requirements
Module: multi_cycle_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; N = WIDTH/CHUNK.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-005 SHALL have port Start, input, 1 bit: request to begin an operation.
REQ-006 SHALL have port Mode, input, 2 bits: operation select; 00 add, 01 sub, 10 add-with-carry, 11 sub-with-carry.
REQ-007 SHALL have port A, input, WIDTH bits: first operand.
REQ-008 SHALL have port B, input, WIDTH bits: second operand.
REQ-009 SHALL have port Cin, input, 1 bit: carry-in, used only in Mode 10 and Mode 11.
REQ-010 SHALL have port Busy, output, 1 bit: an operation is in progress.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-012 SHALL have port Out, output, WIDTH bits: the result.
REQ-013 SHALL have port Cout, output, 1 bit: carry out of the MSB.
REQ-014 SHALL have port Ovf, output, 1 bit: signed two's-complement overflow.
REQ-015 SHALL have port Zero, output, 1 bit: set when the result is all zeros.

Function
REQ-016 SHALL compute, per Mode: 00 A+B+0; 01 A+~B+1; 10 A+B+Cin; 11 A+~B+Cin (modulo 2^WIDTH).
REQ-017 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-018 SHALL accept Start only when Busy=0 (state IDLE or DONE); on acceptance, latch A, B, Mode and the effective carry-in, clear the chunk counter, and enter RUN.
REQ-019 SHALL ignore Start while Busy=1 and SHALL NOT disturb the in-flight latched operands.
REQ-020 SHALL, in each RUN cycle i (i = 0..N-1, LSB chunk first), add chunk i of the latched operands plus the stored carry, write the CHUNK-bit sum into the result shift register, and store the chunk carry for the next cycle.
REQ-021 SHALL keep Busy=1 for exactly N cycles, starting the cycle after the accepting edge.
REQ-022 SHALL enter DONE after the Nth RUN cycle; in DONE, Done=1 for exactly one cycle, and Out, Cout, Ovf and Zero update in that same cycle.
REQ-023 SHALL give a latency, from the Start-accepting edge to Done high, of N+1 rising edges (5 at the defaults).
REQ-024 SHALL go from DONE to RUN if Start=1 in DONE (back-to-back operation); otherwise it SHALL go to IDLE.
REQ-025 SHALL hold Out, Cout, Ovf and Zero stable from one DONE until the next DONE; they SHALL NOT change during RUN.
REQ-026 SHALL set Cout = carry out of bit WIDTH-1; for subtraction, Cout=1 means no borrow.
REQ-027 SHALL set Ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-028 SHALL set Zero = 1 exactly when Out is zero.
REQ-029 SHALL, for CHUNK = WIDTH (N=1), complete in 2 edges with identical results.

Reset
REQ-030 SHALL, while Reset=0 at a rising edge, force: state IDLE, Busy=0, Done=0, Out=0, Cout=0, Ovf=0, Zero=0, and clear the chunk counter and internal carry.
REQ-031 SHALL, on a reset during RUN, abort the operation with no Done pulse and no result update; Start SHALL be ignored while Reset=0.
REQ-032 SHALL accept a Start presented in the first cycle after Reset returns high.

Verification
REQ-033 SHALL pass a basic add: defaults, Mode 00, A=0x0005, B=0x0008, Start pulsed -> Done high 5 edges later, Out=0x000D, Cout=0, Ovf=0, Zero=0.
REQ-034 SHALL pass a wrap-around add: Mode 00, A=0xFFFF, B=0x0001 -> Out=0x0000, Cout=1, Ovf=0, Zero=1.
REQ-035 SHALL pass a signed-overflow add: Mode 00, A=0x7FFF, B=0x0001 -> Out=0x8000, Cout=0, Ovf=1, Zero=0.
REQ-036 SHALL pass borrow-chain tests: Mode 01, A=0x0005, B=0x0008 -> Out=0xFFFD, Cout=0; then Mode 11, Cin=0, A=0x0010, B=0x0001 -> Out=0x000E, Cout=1.
REQ-037 SHALL pass Start while busy: Start at cycle 0 (A=1, B=2), Start again at cycle 2 (A=9, B=9) -> a single Done with Out=0x0003; then Start in the DONE cycle -> next Done exactly 5 edges later.
REQ-038 SHALL pass reset mid-operation: Reset=0 at RUN cycle 2 -> no Done, all outputs 0 the next cycle; new Start after release -> correct result.
